// File: rtl/ysyx_sq.sv
// ----------------------------------------------------------------------------
// ysyx_sq -- committed-store queue
//
// Buffers retired stores in program order and drains them one at a time to
// the data-memory write channel. A combinational lookup port lets younger
// loads detect (and optionally forward from) bytes still sitting in the queue.
//
// Build option:
//   YSYX_SQ_FORWARD_EN  defined   : per-byte forwarding, ld_hit/ld_data live,
//                                   partial coverage reports ld_conflict.
//                       undefined : ld_hit=0, ld_data=0, any overlap reports
//                                   ld_conflict.
//
// Ports:
//   clock, reset                      clock, async active-low reset
//   rou_valid/store/alu/waddr/wdata/pc   commit port (store size in alu[1:0])
//   sq_ready                          queue can take one store this cycle
//   sq_empty                          nothing queued, no write outstanding
//   mem_aw*, mem_wdata, mem_wstrb     write request (word addr, lane data)
//   mem_awready, mem_bvalid, mem_bresp   write handshake / response
//   ld_valid/addr/size                load lookup request
//   ld_hit, ld_data, ld_conflict      lookup result
//   sq_err                            one-cycle pulse on error response
//
// Drain FSM:
//   state  | meaning
//   IDLE   | nothing being written; leaves as soon as an entry exists
//   REQ    | head entry presented on the write channel, waiting awready
//   RESP   | request accepted, waiting bvalid; pop head on response
// ----------------------------------------------------------------------------
module ysyx_sq #(
  parameter int SQ_SIZE = 4,
  parameter int XLEN    = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rou_valid,
  input  logic            rou_store,
  input  logic [4:0]      rou_alu,
  input  logic [XLEN-1:0] rou_waddr,
  input  logic [XLEN-1:0] rou_wdata,
  input  logic [XLEN-1:0] rou_pc,
  output logic            sq_ready,
  output logic            sq_empty,
  output logic            mem_awvalid,
  output logic [XLEN-1:0] mem_awaddr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_awready,
  input  logic            mem_bvalid,
  input  logic [1:0]      mem_bresp,
  input  logic            ld_valid,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [1:0]      ld_size,
  output logic            ld_hit,
  output logic [XLEN-1:0] ld_data,
  output logic            ld_conflict,
  output logic            sq_err
);

  localparam int PW = $clog2(SQ_SIZE);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;

  logic [XLEN-1:0] ent_addr [SQ_SIZE];
  logic [XLEN-1:0] ent_data [SQ_SIZE];
  logic [3:0]      ent_strb [SQ_SIZE];
  logic [XLEN-1:0] ent_pc   [SQ_SIZE];

  logic            do_enq;
  logic            do_pop;
  logic [3:0]      enq_strb;
  logic [3:0]      ld_strb;

  // --------------------------------------------------------------------------
  // Commit side
  // --------------------------------------------------------------------------
  // Ready is purely a function of occupancy: a pop in the same cycle does not
  // make room for an enqueue (keeps commit timing off the memory response).
  assign sq_ready = (count != CW'(SQ_SIZE));
  assign do_enq   = rou_valid && rou_store && sq_ready;
  assign do_pop   = (state == S_RESP) && mem_bvalid;

  assign count_next = count + CW'(do_enq) - CW'(do_pop);

  always_comb begin
    case (rou_alu[1:0])
      2'b00:   enq_strb = 4'b0001 << rou_waddr[1:0];
      2'b01:   enq_strb = 4'b0011 << rou_waddr[1:0];
      default: enq_strb = 4'b1111;
    endcase
  end

  // Entry payload needs no reset: only entries inside [head, head+count) are
  // ever observed.
  always_ff @(posedge clock) begin
    if (do_enq) begin
      ent_addr[tail] <= {rou_waddr[XLEN-1:2], 2'b00};
      ent_data[tail] <= rou_wdata << {rou_waddr[1:0], 3'b000};
      ent_strb[tail] <= enq_strb;
      ent_pc[tail]   <= rou_pc;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy and drain FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      sq_err <= 1'b0;
    end else begin
      sq_err <= do_pop && (mem_bresp != 2'b00);
      count  <= count_next;
      if (do_enq) tail <= tail + 1'b1;
      if (do_pop) head <= head + 1'b1;

      case (state)
        S_IDLE: if (count != '0) state <= S_REQ;
        S_REQ:  if (mem_awready) state <= S_RESP;
        S_RESP: if (mem_bvalid) state <= (count_next != '0) ? S_REQ : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Head cannot move and its slot cannot be rewritten while in REQ, so the
  // request fields stay stable until accepted.
  assign mem_awvalid = (state == S_REQ);
  assign mem_awaddr  = mem_awvalid ? ent_addr[head] : '0;
  assign mem_wdata   = mem_awvalid ? ent_data[head] : '0;
  assign mem_wstrb   = mem_awvalid ? ent_strb[head] : 4'b0000;

  assign sq_empty = (count == '0) && (state == S_IDLE);

  // --------------------------------------------------------------------------
  // Load lookup
  // --------------------------------------------------------------------------
  always_comb begin
    case (ld_size)
      2'b00:   ld_strb = 4'b0001 << ld_addr[1:0];
      2'b01:   ld_strb = 4'b0011 << ld_addr[1:0];
      default: ld_strb = 4'b1111;
    endcase
  end

  logic          ld_ovl;
  logic [PW-1:0] scan_idx;

`ifdef YSYX_SQ_FORWARD_EN
  logic [3:0]      ld_cov;
  logic [XLEN-1:0] ld_fwd;

  // Walk oldest to youngest so a younger entry's byte overwrites an older one.
  always_comb begin
    ld_ovl   = 1'b0;
    ld_cov   = 4'b0000;
    ld_fwd   = '0;
    scan_idx = '0;
    for (int i = 0; i < SQ_SIZE; i++) begin
      scan_idx = head + PW'(i);
      if ((CW'(i) < count) &&
          (ent_addr[scan_idx][XLEN-1:2] == ld_addr[XLEN-1:2]) &&
          ((ent_strb[scan_idx] & ld_strb) != 4'b0000)) begin
        ld_ovl = 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (ent_strb[scan_idx][b] && ld_strb[b]) begin
            ld_cov[b]        = 1'b1;
            ld_fwd[8*b +: 8] = ent_data[scan_idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign ld_hit      = ld_valid && ((ld_cov & ld_strb) == ld_strb);
  assign ld_data     = ld_hit ? ld_fwd : '0;
  assign ld_conflict = ld_valid && ld_ovl && !ld_hit;
`else
  always_comb begin
    ld_ovl   = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < SQ_SIZE; i++) begin
      scan_idx = head + PW'(i);
      if ((CW'(i) < count) &&
          (ent_addr[scan_idx][XLEN-1:2] == ld_addr[XLEN-1:2]) &&
          ((ent_strb[scan_idx] & ld_strb) != 4'b0000))
        ld_ovl = 1'b1;
    end
  end

  assign ld_hit      = 1'b0;
  assign ld_data     = '0;
  assign ld_conflict = ld_valid && ld_ovl;
`endif

  // Upper alu bits and the stored pc are carried for trace only.
  logic unused_trace;
  assign unused_trace = ^{rou_alu[4:2], ent_pc[head]};

  // The commit unit must hold a store while sq_ready is low.
  assert property (@(posedge clock) disable iff (!reset)
                   !(rou_valid && rou_store && !sq_ready))
    else $error("ysyx_sq: store committed while queue full");

endmodule

// File: tb/tb_ysyx_sq.sv
module tb_ysyx_sq;
  localparam int SQ = 4;

  logic        clock;
  logic        reset;
  logic        rou_valid, rou_store;
  logic [4:0]  rou_alu;
  logic [31:0] rou_waddr, rou_wdata, rou_pc;
  logic        sq_ready, sq_empty;
  logic        mem_awvalid;
  logic [31:0] mem_awaddr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_awready, mem_bvalid;
  logic [1:0]  mem_bresp;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_conflict;
  logic        sq_err;

  ysyx_sq #(.SQ_SIZE(SQ), .XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .rou_valid(rou_valid), .rou_store(rou_store), .rou_alu(rou_alu),
    .rou_waddr(rou_waddr), .rou_wdata(rou_wdata), .rou_pc(rou_pc),
    .sq_ready(sq_ready), .sq_empty(sq_empty),
    .mem_awvalid(mem_awvalid), .mem_awaddr(mem_awaddr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_awready(mem_awready), .mem_bvalid(mem_bvalid),
    .mem_bresp(mem_bresp),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_conflict(ld_conflict),
    .sq_err(sq_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: stores kept as (byte address, right-aligned data, byte length),
  // oldest first, until their write response arrives.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          len;
  } st_t;

  st_t pend[$];
  int  total, bad;
  bit  outst, aw_hold, force_aw, err_force, ld_rand, exp_err;
  int  bdly, bdly_max, n_wr;
  logic [31:0] last_awaddr, last_wdata;
  logic [3:0]  last_wstrb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int sz_len(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Expected memory-side image of a store, built byte by byte.
  function automatic void wr_image(input st_t s, output logic [31:0] a,
                                   output logic [31:0] d, output logic [3:0] sb);
    int lane;
    a  = s.a & ~32'h3;
    d  = '0;
    sb = '0;
    for (int k = 0; k < s.len; k++) begin
      lane = int'((s.a + 32'(k)) & 32'h3);
      d[8*lane +: 8] = s.d[8*k +: 8];
      sb[lane] = 1'b1;
    end
  endfunction

  function automatic void ld_ref(input logic [31:0] a, input logic [1:0] sz,
                                 output logic hit, output logic [31:0] data,
                                 output logic conf);
    int          n;
    logic [31:0] base, ba, off;
    logic        any, all, found;
    logic [31:0] img;
    st_t         e;
    n    = sz_len(sz);
    base = (n == 4) ? (a & ~32'h3) : a;
    any  = 1'b0;
    all  = 1'b1;
    img  = '0;
    for (int k = 0; k < n; k++) begin
      ba    = base + 32'(k);
      found = 1'b0;
      for (int j = pend.size() - 1; j >= 0; j--) begin
        e = pend[j];
        if (!found && ba >= e.a && ba < e.a + 32'(e.len)) begin
          found = 1'b1;
          off   = ba - e.a;
          img[8*ba[1:0] +: 8] = e.d[8*off +: 8];
        end
      end
      any = any | found;
      all = all & found;
    end
`ifdef YSYX_SQ_FORWARD_EN
    hit  = all;
    data = all ? img : 32'h0;
    conf = any && !all;
`else
    hit  = 1'b0;
    data = 32'h0;
    conf = any;
`endif
  endfunction

  function automatic void gen_access(output logic [31:0] a, output logic [1:0] sz);
    sz = 2'($urandom_range(0, 2));
    a  = (($urandom_range(0, 1) == 1) ? 32'h0000_0100 : 32'h8000_0000)
         + 32'(4 * $urandom_range(0, 3));
    if (sz == 2'b00) a = a + 32'($urandom_range(0, 3));
    else if (sz == 2'b01) a = a + 32'(2 * $urandom_range(0, 1));
  endfunction

  // One clock: play the memory slave, offer commit/load inputs, check lookup
  // before the edge, advance the model on the edge, check status after it.
  task automatic cycle(input logic v, input logic st, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz, output logic acc);
    logic        hs, pop, eh, ec, e;
    logic [31:0] ed, ea, ewd;
    logic [3:0]  es;
    logic [1:0]  lsz;
    logic [31:0] la;
    st_t         s;
    hs = 1'b0; pop = 1'b0; e = 1'b0;
    mem_awready = 1'b0; mem_bvalid = 1'b0; mem_bresp = 2'b00;
    if (outst) begin
      if (bdly == 0) begin
        e = err_force || ($urandom_range(0, 7) == 0);
        err_force  = 1'b0;
        mem_bvalid = 1'b1;
        mem_bresp  = e ? 2'($urandom_range(1, 3)) : 2'b00;
        pop = 1'b1;
      end else begin
        bdly--;
      end
    end else if (mem_awvalid && !aw_hold && (force_aw || $urandom_range(0, 2) != 0)) begin
      mem_awready = 1'b1;
      hs = 1'b1;
      last_awaddr = mem_awaddr;
      last_wdata  = mem_wdata;
      last_wstrb  = mem_wstrb;
      if (pend.size() == 0) check("aw_spurious", 32'd1, 32'd0);
      else begin
        wr_image(pend[0], ea, ewd, es);
        check("aw_addr", mem_awaddr, ea);
        check("aw_data", mem_wdata, ewd);
        check("aw_strb", 32'(mem_wstrb), 32'(es));
      end
    end
    acc = v && st && (pend.size() != SQ);
    rou_valid = v && (!st || acc);
    rou_store = st;
    rou_waddr = a;
    rou_wdata = d;
    rou_alu   = {3'($urandom_range(0, 7)), sz};
    rou_pc    = $urandom;
    if (ld_rand) begin
      gen_access(la, lsz);
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_addr  = la;
      ld_size  = lsz;
    end
    #1;
    if (ld_valid) ld_ref(ld_addr, ld_size, eh, ed, ec);
    else begin eh = 1'b0; ed = 32'h0; ec = 1'b0; end
    check("ld_hit", 32'(ld_hit), 32'(eh));
    check("ld_data", ld_data, ed);
    check("ld_conflict", 32'(ld_conflict), 32'(ec));
    @(posedge clock);
    if (hs) begin outst = 1'b1; bdly = $urandom_range(0, bdly_max); end
    if (pop) begin
      outst = 1'b0;
      void'(pend.pop_front());
      n_wr++;
    end
    exp_err = pop && e;
    if (acc) begin
      s.a = a; s.d = d; s.len = sz_len(sz);
      pend.push_back(s);
    end
    @(negedge clock);
    rou_valid = 1'b0; mem_awready = 1'b0; mem_bvalid = 1'b0; mem_bresp = 2'b00;
    check("sq_ready", 32'(sq_ready), 32'(pend.size() != SQ));
    check("sq_empty", 32'(sq_empty), 32'(pend.size() == 0 && !outst));
    check("sq_err", 32'(sq_err), 32'(exp_err));
  endtask

  task automatic commit(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    logic acc;
    int   n;
    n = 0;
    do begin
      cycle(1'b1, 1'b1, a, d, sz, acc);
      n++;
    end while (!acc && n < 100);
    if (!acc) check("commit_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, acc);
  endtask

  task automatic drain(input int budget);
    logic acc;
    int   n;
    n = 0;
    while ((pend.size() != 0 || outst) && n < budget) begin
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, acc);
      n++;
    end
    check("drain_timeout", 32'(pend.size() == 0 && !outst), 32'd1);
    check("drain_empty", 32'(sq_empty), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [31:0] a, d;
    logic [1:0]  sz;
    int          n, w0;
    total = 0; bad = 0; outst = 0; aw_hold = 0; force_aw = 0; err_force = 0;
    ld_rand = 0; exp_err = 0; bdly = 0; bdly_max = 0; n_wr = 0;
    reset = 1'b0;
    rou_valid = 0; rou_store = 0; rou_alu = 0; rou_waddr = 0; rou_wdata = 0; rou_pc = 0;
    mem_awready = 0; mem_bvalid = 0; mem_bresp = 0;
    ld_valid = 0; ld_addr = 0; ld_size = 0;

    #1;
    check("rst_ready", 32'(sq_ready), 32'd1);
    check("rst_empty", 32'(sq_empty), 32'd1);
    check("rst_awvalid", 32'(mem_awvalid), 32'd0);
    check("rst_awaddr", mem_awaddr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_err", 32'(sq_err), 32'd0);
    check("rst_ld", 32'({ld_hit, ld_conflict}), 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;

    // Single SW, immediate handshakes.
    force_aw = 1; bdly_max = 0;
    commit(32'h8000_0004, 32'hDEAD_BEEF, 2'b10);
    n = 0;
    while (!sq_empty && n < 10) begin idle(1); n++; end
    check("sw_latency_ok", 32'(n <= 4), 32'd1);
    check("sw_awaddr", last_awaddr, 32'h8000_0004);
    check("sw_wstrb", 32'(last_wstrb), 32'hF);
    check("sw_wdata", last_wdata, 32'hDEAD_BEEF);

    // SB to the top byte lane.
    commit(32'h8000_0003, 32'h0000_00AB, 2'b00);
    drain(20);
    check("sb_awaddr", last_awaddr, 32'h8000_0000);
    check("sb_wstrb", 32'(last_wstrb), 32'h8);
    check("sb_wdata", last_wdata, 32'hAB00_0000);

    // Fill while the write channel is stalled, then release.
    aw_hold = 1;
    for (int i = 0; i < 4; i++) commit(32'h100 + 32'(4*i), 32'h1000 + 32'(i), 2'b10);
    check("full_ready", 32'(sq_ready), 32'd0);
    idle(3);
    check("full_hold", 32'(sq_ready), 32'd0);
    aw_hold = 0;
    commit(32'h110, 32'h1004, 2'b10);
    drain(60);
    check("full_order_count", 32'(n_wr), 32'd7);

    // Back-to-back commits overlapping drains: pointer wrap, enq+pop same cycle.
    for (int i = 0; i < 9; i++) commit(32'h8000_0000 + 32'(4*(i%4)), 32'hA0 + 32'(i), 2'b10);
    drain(60);
    check("wrap_count", 32'(n_wr), 32'd16);

    // Lookup against held stores.
    aw_hold = 1;
    commit(32'h100, 32'h1122_3344, 2'b10);
    commit(32'h101, 32'h0000_0055, 2'b00);
    ld_valid = 1; ld_addr = 32'h100; ld_size = 2'b10;
    #1;
`ifdef YSYX_SQ_FORWARD_EN
    check("fwd_hit", 32'(ld_hit), 32'd1);
    check("fwd_data", ld_data, 32'h1122_5544);
    check("fwd_conflict", 32'(ld_conflict), 32'd0);
`else
    check("nf_hit", 32'(ld_hit), 32'd0);
    check("nf_data", ld_data, 32'd0);
    check("nf_conflict", 32'(ld_conflict), 32'd1);
`endif
    ld_addr = 32'h104;
    #1;
    check("miss_hit", 32'(ld_hit), 32'd0);
    check("miss_conflict", 32'(ld_conflict), 32'd0);
    ld_valid = 0;

    // Error response on the first drain: pulse, entry still popped.
    aw_hold = 0; err_force = 1;
    w0 = n_wr; n = 0;
    while (n_wr == w0 && n < 20) begin idle(1); n++; end
    check("err_pulse", 32'(sq_err), 32'd1);
    idle(1);
    check("err_clear", 32'(sq_err), 32'd0);
    drain(20);

    // Reset while a write is outstanding.
    bdly_max = 4;
    commit(32'h8000_0008, 32'h5555_AAAA, 2'b10);
    n = 0;
    while (!outst && n < 20) begin idle(1); n++; end
    check("resp_reached", 32'(outst), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_awvalid", 32'(mem_awvalid), 32'd0);
    check("rst_mid_empty", 32'(sq_empty), 32'd1);
    check("rst_mid_ready", 32'(sq_ready), 32'd1);
    pend.delete(); outst = 0; exp_err = 0;
    @(posedge clock); @(negedge clock);
    reset = 1'b1;
    idle(2);

    // Randomized traffic.
    force_aw = 0; bdly_max = 2; ld_rand = 1;
    for (int i = 0; i < 500; i++) begin
      gen_access(a, sz);
      d = $urandom;
      if (sz == 2'b00) d = d & 32'hFF;
      else if (sz == 2'b01) d = d & 32'hFFFF;
      if ($urandom_range(0, 2) != 0) cycle(1'b1, 1'b1, a, d, sz, acc);
      else cycle(1'($urandom_range(0, 1)), 1'b0, a, d, sz, acc);
    end
    ld_rand = 0; ld_valid = 0;
    drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
